frame_capture_ctrl: RTL and testbench

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/cam_pkg.sv | 17 +
 rtl/cam_byte_pair.sv | 40 ++++
 rtl/frame_capture_ctrl.sv | 169 ++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared camera-path definitions: default frame geometry, buffer address width
// and the capture FSM state type, reused by the VGA reader and the arbiter.
package cam_pkg;

    localparam int H_PIX     = 320;
    localparam int V_LINES   = 240;
    localparam int FRAME_PIX = H_PIX * V_LINES;
    localparam int ADDR_W    = 17;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/cam_byte_pair.sv
// Pairs camera bytes into RGB565 pixels and flags the end of each HREF line.
module cam_byte_pair (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        i_en,
    input  logic        i_hr,
    input  logic [7:0]  i_d,
    output logic        o_pix_valid,
    output logic [15:0] o_pix,
    output logic        o_line_end
);

    logic       r_phase;
    logic       r_hr_d;
    logic [7:0] r_hi;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_phase <= 1'b0;
            r_hr_d  <= 1'b0;
            r_hi    <= 8'h00;
        end else begin
            r_hr_d <= i_hr;
            // Phase restarts at every line so an odd trailing byte never pairs
            // with the first byte of the next line.
            if (i_en && i_hr) begin
                r_phase <= ~r_phase;
                if (!r_phase)
                    r_hi <= i_d;
            end else begin
                r_phase <= 1'b0;
            end
        end
    end

    assign o_pix_valid = i_en & i_hr & r_phase;
    assign o_pix       = {r_hi, i_d};
    assign o_line_end  = r_hr_d & ~i_hr;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Camera frame capture: waits for a frame boundary, writes RGB565 pixels to the
// frame buffer, counts lines/frames and flags frames of the wrong size.
module frame_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_PIX   = cam_pkg::H_PIX,
    parameter int V_LINES = cam_pkg::V_LINES,
    parameter int ADDR_W  = cam_pkg::ADDR_W
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              start,
    input  logic              abort,
    input  logic              mode_cont,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       dout,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_cnt,
    output logic [8:0]        line_cnt,
    output logic              err_size
);

    // One spare index bit so oversize frames still count past the buffer end.
    localparam int               PIX_W   = ADDR_W + 1;
    localparam logic [PIX_W-1:0] FRAME_N = PIX_W'(H_PIX * V_LINES);
    localparam logic [8:0]       LINES_N = 9'(V_LINES);

    logic             r_vs, r_vs_d, r_hr;
    logic [7:0]       r_d;
    cap_state_t       r_state, w_state_next;
    logic [PIX_W-1:0] r_pix_idx;
    logic             r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]      r_dout;
    logic [7:0]       r_frame_cnt;
    logic [8:0]       r_line_cnt;
    logic             r_err;

    logic             w_vs_fall, w_vs_rise, w_capture;
    logic             w_enter_cap, w_frame_done, w_busy, w_clear_err;
    logic             w_pix_valid, w_line_end;
    logic [15:0]      w_pix;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
            r_hr   <= 1'b0;
            r_d    <= 8'h00;
        end else begin
            r_vs   <= vsync;
            r_vs_d <= r_vs;
            r_hr   <= href;
            r_d    <= d;
        end
    end

    assign w_vs_fall = r_vs_d & ~r_vs;
    assign w_vs_rise = ~r_vs_d & r_vs;
    assign w_capture = (r_state == CAPTURE);

    cam_byte_pair u_byte_pair (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .i_en        (w_capture),
        .i_hr        (r_hr),
        .i_d         (r_d),
        .o_pix_valid (w_pix_valid),
        .o_pix       (w_pix),
        .o_line_end  (w_line_end)
    );

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_enter_cap  = 1'b0;
        w_frame_done = 1'b0;
        w_clear_err  = 1'b0;
        w_busy       = (r_state != IDLE);
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = WAIT_VS;
                    w_clear_err  = 1'b1;
                end
            end
            WAIT_VS: begin
                if (w_vs_fall) begin
                    w_state_next = CAPTURE;
                    w_enter_cap  = 1'b1;
                end
            end
            CAPTURE: begin
                if (w_vs_rise)
                    w_state_next = DONE;
            end
            DONE: begin
                w_state_next = mode_cont ? WAIT_VS : IDLE;
                w_frame_done = 1'b1;
            end
            default: w_state_next = IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start.
        if (abort) begin
            w_state_next = IDLE;
            w_enter_cap  = 1'b0;
            w_frame_done = 1'b0;
            w_clear_err  = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_pix_idx   <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_dout      <= 16'h0000;
            r_frame_cnt <= 8'h00;
            r_line_cnt  <= 9'd0;
            r_err       <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_enter_cap) begin
                r_pix_idx  <= '0;
                r_line_cnt <= 9'd0;
            end else if (w_capture && !abort) begin
                if (w_pix_valid) begin
                    if (r_pix_idx < FRAME_N) begin
                        r_we   <= 1'b1;
                        r_addr <= r_pix_idx[ADDR_W-1:0];
                        r_dout <= w_pix;
                    end
                    if (r_pix_idx != '1)
                        r_pix_idx <= r_pix_idx + 1'b1;
                end
                if (w_line_end && r_line_cnt != 9'd511)
                    r_line_cnt <= r_line_cnt + 1'b1;
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
                if (r_pix_idx != FRAME_N || r_line_cnt != LINES_N)
                    r_err <= 1'b1;
            end
            if (w_clear_err)
                r_err <= 1'b0;
        end
    end

    assign we         = r_we;
    assign addr       = r_addr;
    assign dout       = r_dout;
    assign busy       = w_busy;
    assign frame_done = w_frame_done;
    assign frame_cnt  = r_frame_cnt;
    assign line_cnt   = r_line_cnt;
    assign err_size   = r_err;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed-sequence bench with random pixel data; expected buffer writes are
// derived from the bytes sent, frame geometry and the documented latencies.
module tb_frame_capture_ctrl;

    localparam int H      = 8;
    localparam int V      = 6;
    localparam int ADDR_W = 17;
    localparam int FRAME  = H * V;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, abort, mode_cont, vsync, href;
    logic [7:0]        d;
    logic              we, busy, frame_done, err_size;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       dout;
    logic [7:0]        frame_cnt;
    logic [8:0]        line_cnt;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    int fd_exp = 0;
    int fc_exp = 0;

    logic [ADDR_W+15:0] wq[$];
    logic [ADDR_W+15:0] exp_q[$];

    frame_capture_ctrl #(.H_PIX(H), .V_LINES(V), .ADDR_W(ADDR_W)) dut (
        .iCLK       (clk),
        .iRST_N     (rst_n),
        .start      (start),
        .abort      (abort),
        .mode_cont  (mode_cont),
        .vsync      (vsync),
        .href       (href),
        .d          (d),
        .we         (we),
        .addr       (addr),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .line_cnt   (line_cnt),
        .err_size   (err_size)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we)
            wq.push_back({addr, dout});
        if (frame_done)
            fd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_writes(input string tag);
        int n_bad;
        n_bad = 0;
        $display("%s: writes seen=%0d expected=%0d", tag, wq.size(), exp_q.size());
        check({tag, "_count"}, wq.size(), exp_q.size());
        for (int i = 0; i < wq.size() && i < exp_q.size(); i++)
            if (wq[i] !== exp_q[i])
                n_bad++;
        check({tag, "_data"}, n_bad, 0);
        wq.delete();
        exp_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives one camera frame (vsync low .. vsync high). When cap is set the
    // expected writes are queued: pixel k of the frame goes to address k if it
    // fits the buffer. Pixel abort_pix's first byte carries an abort pulse.
    task automatic drive_frame(input int nlines, input int nbytes, input bit cap,
                               input int start_line, input int mc_off_line, input int abort_pix);
        int         idx;
        bit         live;
        bit         just_aborted;
        logic [7:0] hi;
        idx = 0;
        live = cap;
        just_aborted = 1'b0;
        hi = 8'h00;
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        for (int l = 0; l < nlines; l++) begin
            if (l == start_line)
                pulse_start();
            if (l == mc_off_line)
                mode_cont = 1'b0;
            for (int b = 0; b < nbytes; b++) begin
                if (just_aborted) begin
                    abort = 1'b0;
                    just_aborted = 1'b0;
                    check("abort_we_next", {31'd0, we}, 32'd0);
                    check("abort_busy_next", {31'd0, busy}, 32'd0);
                end
                href = 1'b1;
                d = 8'($urandom);
                if (b % 2 == 0) begin
                    hi = d;
                    if (live && idx == abort_pix) begin
                        abort = 1'b1;
                        just_aborted = 1'b1;
                        live = 1'b0;
                        // The previous pixel's write would land on the same edge
                        // the abort takes effect, so it never happens.
                        if (exp_q.size() > 0)
                            void'(exp_q.pop_back());
                    end
                end else begin
                    if (live && idx < FRAME)
                        exp_q.push_back({ADDR_W'(idx), hi, d});
                    idx++;
                end
                @(negedge clk);
            end
            href = 1'b0;
            d = 8'h00;
            repeat (3) @(negedge clk);
        end
        vsync = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode_cont = 1'b0;
        vsync = 1'b1;
        href = 1'b0;
        d = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);
        check("rst_err", {31'd0, err_size}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single-shot full frame.
        pulse_start();
        drive_frame(V, 2 * H, 1'b1, -1, -1, -1);
        fd_exp++; fc_exp++;
        cmp_writes("single");
        check("single_fd", fd_cnt, fd_exp);
        check("single_frame_cnt", 32'(frame_cnt), fc_exp);
        check("single_err", {31'd0, err_size}, 32'd0);
        check("single_busy", {31'd0, busy}, 32'd0);
        check("single_line_cnt", 32'(line_cnt), V);

        // Pixel packing and write latency: one pixel, one line.
        pulse_start();
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        href = 1'b1; d = 8'hF8;
        @(negedge clk);
        d = 8'h1F;
        @(negedge clk);
        href = 1'b0; d = 8'h00;
        check("pack_we_early", {31'd0, we}, 32'd0);
        @(negedge clk);
        check("pack_we", {31'd0, we}, 32'd1);
        check("pack_dout", 32'(dout), 32'h0000F81F);
        check("pack_addr", 32'(addr), 32'd0);
        @(negedge clk);
        check("pack_we_late", {31'd0, we}, 32'd0);
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (6) @(negedge clk);
        exp_q.push_back({ADDR_W'(0), 16'hF81F});
        fd_exp++; fc_exp++;
        cmp_writes("pack");
        check("pack_fd", fd_cnt, fd_exp);
        check("pack_err", {31'd0, err_size}, 32'd1);

        // Start in IDLE clears the sticky error; then a short frame sets it again.
        pulse_start();
        @(negedge clk);
        check("err_cleared", {31'd0, err_size}, 32'd0);
        drive_frame(V - 1, 2 * H, 1'b1, -1, -1, -1);
        fd_exp++; fc_exp++;
        cmp_writes("short");
        check("short_fd", fd_cnt, fd_exp);
        check("short_err", {31'd0, err_size}, 32'd1);
        check("short_line_cnt", 32'(line_cnt), V - 1);

        // Start mid-frame: that frame is skipped, the next one captured.
        drive_frame(V, 2 * H, 1'b0, 2, -1, -1);
        check("skip_fd", fd_cnt, fd_exp);
        check("skip_busy", {31'd0, busy}, 32'd1);
        drive_frame(V, 2 * H, 1'b1, -1, -1, -1);
        fd_exp++; fc_exp++;
        cmp_writes("skip_next");
        check("skip_next_fd", fd_cnt, fd_exp);
        check("skip_next_err", {31'd0, err_size}, 32'd0);

        // Continuous mode: three frames from one start, mode dropped in frame 3.
        mode_cont = 1'b1;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            drive_frame(V, 2 * H, 1'b1, -1, (f == 2) ? 3 : -1, -1);
            fd_exp++; fc_exp++;
            cmp_writes("cont");
            check("cont_frame_cnt", 32'(frame_cnt), fc_exp);
            check("cont_busy", {31'd0, busy}, (f == 2) ? 32'd0 : 32'd1);
        end
        check("cont_fd", fd_cnt, fd_exp);
        check("cont_err", {31'd0, err_size}, 32'd0);

        // Abort mid-frame at pixel 20.
        pulse_start();
        drive_frame(V, 2 * H, 1'b1, -1, -1, 20);
        cmp_writes("abort");
        check("abort_fd", fd_cnt, fd_exp);
        check("abort_frame_cnt", 32'(frame_cnt), fc_exp);
        check("abort_busy", {31'd0, busy}, 32'd0);

        // Start together with abort: abort wins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("start_abort_busy2", {31'd0, busy}, 32'd0);

        // Oversize frame: writes stop at the buffer end, error flagged.
        pulse_start();
        drive_frame(V + 1, 2 * (H + 1), 1'b1, -1, -1, -1);
        fd_exp++; fc_exp++;
        cmp_writes("oversize");
        check("oversize_fd", fd_cnt, fd_exp);
        check("oversize_err", {31'd0, err_size}, 32'd1);
        check("oversize_line_cnt", 32'(line_cnt), V + 1);

        // Asynchronous reset in the middle of a capture.
        pulse_start();
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        for (int b = 0; b < 4; b++) begin
            href = 1'b1; d = 8'($urandom);
            @(negedge clk);
        end
        href = 1'b0;
        repeat (3) @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            href = 1'b1; d = 8'($urandom) | 8'h01;
            @(negedge clk);
        end
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", {31'd0, we}, 32'd0);
        check("arst_addr", 32'(addr), 32'd0);
        check("arst_dout", 32'(dout), 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_frame_done", {31'd0, frame_done}, 32'd0);
        check("arst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("arst_line_cnt", 32'(line_cnt), 32'd0);
        check("arst_err", {31'd0, err_size}, 32'd0);
        href = 1'b0; vsync = 1'b1; d = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        wq.delete();
        repeat (3) @(negedge clk);
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
